shifter_pipe_n: RTL and testbench

//  Parametrised successor of the execution-unit shifter: width-generic W-bit barrel shifter/rotator with

---
 rtl/shifter_pipe_n_if.sv | 42 ++++
 rtl/shifter_pipe_n.sv | 183 ++++++++++++++++++
 tb/tb_shifter_pipe_n.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shifter_pipe_n_if.sv
// Operation/result bundle for the execution-cluster shifter.
// Latency: none, wiring only.
// Backpressure: stall comes from downstream. busy mirrors it back to the issuer.
// Ports: the master drives act/stall/opr/a/b/c/d/sa/sd/dsti.
//        The slave (the shifter) drives busy/r/dsto/sr/rdy/zero/sign/cout/ovr.
interface shifter_pipe_n_if #(
  parameter int W    = 64,
  parameter int TAGW = 5
);
  localparam int CW  = $clog2(W);
  localparam int SZW = $clog2(W / 8);

  logic            act;
  logic            stall;
  logic            busy;
  logic [2:0]      opr;
  logic [W-1:0]    a;
  logic [CW-1:0]   b;
  logic [CW:0]     c;
  logic [W-1:0]    d;
  logic [SZW-1:0]  sa;
  logic [SZW-1:0]  sd;
  logic [TAGW-1:0] dsti;
  logic [W-1:0]    r;
  logic [TAGW-1:0] dsto;
  logic [SZW-1:0]  sr;
  logic            rdy;
  logic            zero;
  logic            sign;
  logic            cout;
  logic            ovr;

  modport master (
    output act, stall, opr, a, b, c, d, sa, sd, dsti,
    input  busy, r, dsto, sr, rdy, zero, sign, cout, ovr
  );

  modport slave (
    input  act, stall, opr, a, b, c, d, sa, sd, dsti,
    output busy, r, dsto, sr, rdy, zero, sign, cout, ovr
  );
endinterface

// File: rtl/shifter_pipe_n.sv
// W-bit shifter/rotator with field set/get, per-op flags, and a destination tag.
// Latency: 3 register stages; the result is valid after the third edge counting the accepting edge.
// Backpressure: stall freezes every stage, including outputs and rdy. busy equals stall.
// Ports: clk, reset (synchronous, active high), and bus (shifter_pipe_n_if.slave).
module shifter_pipe_n #(
  parameter int W    = 64,
  parameter int TAGW = 5
) (
  input  logic           clk,
  input  logic           reset,
  shifter_pipe_n_if.slave bus
);
  localparam int CW  = $clog2(W);
  localparam int SZW = $clog2(W / 8);

  typedef enum logic [2:0] {
    OP_LSL = 3'b000, OP_LSR = 3'b001, OP_ROL = 3'b010, OP_ROR = 3'b011,
    OP_RSV = 3'b100, OP_ASR = 3'b101, OP_SET = 3'b110, OP_GET = 3'b111
  } op_e;

  // Returns ones in bits [x-1:0]. Any x >= W saturates to all ones.
  function automatic logic [W-1:0] lowmask(input logic [CW+1:0] x);
    logic [W-1:0] m;
    if (x >= (CW+2)'(W)) m = '1;
    else                 m = (W'(1) << x) - W'(1);
    return m;
  endfunction

  assign bus.busy = bus.stall;

  // ---------------- stage 1: decode size, mask operands, reduce count
  logic [CW:0]   n_in;
  logic [CW-1:0] k_in;
  logic [W-1:0]  nmask_in;

  always_comb begin
    n_in = (CW+1)'(W);
    // Size codes beyond the widest legal one clamp to the full width.
    if (32'(bus.sa) < CW - 3) n_in = (CW+1)'(8) << bus.sa;
    // n is a power of two, so B mod n is a mask.
    k_in     = bus.b & CW'(n_in - (CW+1)'(1));
    nmask_in = lowmask((CW+2)'(n_in));
  end

  logic            v1;
  op_e             op1;
  logic [W-1:0]    a1, d1, nmask1;
  logic [CW-1:0]   k1;
  logic [CW:0]     c1, n1;
  logic [SZW-1:0]  sd1;
  logic [TAGW-1:0] dst1;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
    end else if (!bus.stall) begin
      v1 <= bus.act;
      if (bus.act) begin
        op1    <= op_e'(bus.opr);
        a1     <= bus.a & nmask_in;
        d1     <= bus.d & nmask_in;
        nmask1 <= nmask_in;
        k1     <= k_in;
        c1     <= bus.c;
        n1     <= n_in;
        sd1    <= bus.sd;
        dst1   <= bus.dsti;
      end
    end
  end

  // ---------------- stage 2: shift network, field masks, carry/overflow
  logic [CW-1:0]  nm1;
  logic [CW:0]    nk;
  logic [CW+1:0]  sum, hi, gw;
  logic           sgn, kz;
  logic [W-1:0]   shl, shr, rol, ror, asr, fmask, gmask, win;
  logic [W-1:0]   res_c;
  logic           cout_c, ovr_c;

  always_comb begin
    nm1   = CW'(n1 - (CW+1)'(1));
    nk    = n1 - (CW+1)'(k1);
    sgn   = a1[nm1];
    kz    = (k1 == '0);
    shl   = (a1 << k1) & nmask1;
    shr   = a1 >> k1;
    // A shift by nk == W yields zero, which covers the k == 0 case of both rotates.
    rol   = ((a1 << k1) | (a1 >> nk)) & nmask1;
    ror   = (shr | (a1 << nk)) & nmask1;
    asr   = shr | (sgn ? (nmask1 & ~(nmask1 >> k1)) : '0);
    sum   = (CW+2)'(k1) + (CW+2)'(c1);
    hi    = (sum > (CW+2)'(n1)) ? (CW+2)'(n1) : sum;
    fmask = lowmask(hi) & ~lowmask((CW+2)'(k1));
    gw    = (c1 > n1) ? (CW+2)'(n1) : (CW+2)'(c1);
    gmask = lowmask(gw);
    // Bits [n-1 : n-1-k] all have to match the sign bit for the shift to be overflow free.
    win   = nmask1 & ~lowmask((CW+2)'(nm1 - k1));

    res_c  = '0;
    cout_c = 1'b0;
    ovr_c  = 1'b0;
    case (op1)
      OP_LSL: begin
        res_c  = shl;
        cout_c = ~kz & a1[CW'(nk)];
        ovr_c  = |((sgn ? ~a1 : a1) & win);
      end
      OP_LSR: begin res_c = shr; cout_c = ~kz & a1[k1 - CW'(1)]; end
      OP_ASR: begin res_c = asr; cout_c = ~kz & a1[k1 - CW'(1)]; end
      OP_ROL: begin res_c = rol; cout_c = ~kz & rol[0];          end
      OP_ROR: begin res_c = ror; cout_c = ~kz & ror[nm1];        end
      OP_SET: res_c = (d1 & ~fmask) | (shl & fmask);
      OP_GET: res_c = shr & gmask;
      default: res_c = '0;
    endcase
  end

  logic            v2, cout2, ovr2;
  logic [W-1:0]    res2, nmask2;
  logic [CW-1:0]   nm12;
  logic [SZW-1:0]  sd2;
  logic [TAGW-1:0] dst2;

  always_ff @(posedge clk) begin
    if (reset) begin
      v2 <= 1'b0;
    end else if (!bus.stall) begin
      v2 <= v1;
      if (v1) begin
        res2   <= res_c;
        cout2  <= cout_c;
        ovr2   <= ovr_c;
        nmask2 <= nmask1;
        nm12   <= nm1;
        sd2    <= sd1;
        dst2   <= dst1;
      end
    end
  end

  // ---------------- stage 3: output registers. The data holds across bubbles.
  logic [W-1:0]    r_q;
  logic [TAGW-1:0] dsto_q;
  logic [SZW-1:0]  sr_q;
  logic            rdy_q, zero_q, sign_q, cout_q, ovr_q;
  logic [W-1:0]    rfin;

  assign rfin = res2 & nmask2;

  always_ff @(posedge clk) begin
    if (reset) begin
      rdy_q  <= 1'b0;
      r_q    <= '0;
      dsto_q <= '0;
      sr_q   <= '0;
      zero_q <= 1'b0;
      sign_q <= 1'b0;
      cout_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else if (!bus.stall) begin
      rdy_q <= v2;
      if (v2) begin
        r_q    <= rfin;
        dsto_q <= dst2;
        sr_q   <= sd2;
        zero_q <= (rfin == '0);
        sign_q <= res2[nm12];
        cout_q <= cout2;
        ovr_q  <= ovr2;
      end
    end
  end

  assign bus.r    = r_q;
  assign bus.dsto = dsto_q;
  assign bus.sr   = sr_q;
  assign bus.rdy  = rdy_q;
  assign bus.zero = zero_q;
  assign bus.sign = sign_q;
  assign bus.cout = cout_q;
  assign bus.ovr  = ovr_q;
endmodule

// File: tb/tb_shifter_pipe_n.sv
// Self-checking bench for shifter_pipe_n with W=64 and TAGW=5.
// Directed cases cover fixed results; randomized traffic with stalls is scored against a bit-level model.
// Outputs are sampled 1 time unit after each rising edge.
module tb_shifter_pipe_n;
  typedef struct packed {
    logic [2:0]  opr;
    logic [63:0] a;
    logic [5:0]  b;
    logic [6:0]  c;
    logic [63:0] d;
    logic [2:0]  sa;
    logic [2:0]  sd;
    logic [4:0]  dst;
  } op_t;

  typedef struct packed {
    logic [63:0] r;
    logic        zero, sign, cout, ovr;
    logic [4:0]  dst;
    logic [2:0]  sr;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  res_t q[$];

  always #5 clk = ~clk;

  shifter_pipe_n_if #(.W(64), .TAGW(5)) bus ();
  shifter_pipe_n #(.W(64), .TAGW(5)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference: the result is built bit by bit from the operation rules. Overflow is judged arithmetically.
  function automatic res_t model(input op_t o);
    res_t x;
    int n, k;
    logic [63:0] a, r;
    logic signed [135:0] v, lim, one;
    n = (o.sa > 3) ? 64 : (8 << o.sa);
    k = int'(o.b) % n;
    a = '0;
    r = '0;
    for (int i = 0; i < n; i++) a[i] = o.a[i];
    for (int i = 0; i < n; i++) begin
      case (o.opr)
        3'b000: if (i >= k) r[i] = a[i-k];
        3'b001: if (i + k < n) r[i] = a[i+k];
        3'b101: if (i + k < n) r[i] = a[i+k]; else r[i] = a[n-1];
        3'b010: r[i] = a[(i - k + n) % n];
        3'b011: r[i] = a[(i + k) % n];
        3'b110: if (i >= k && i < k + int'(o.c)) r[i] = a[i-k]; else r[i] = o.d[i];
        3'b111: if (i < int'(o.c) && i + k < n) r[i] = a[i+k];
        default: r[i] = 1'b0;
      endcase
    end
    x.r    = r;
    x.zero = (r == '0);
    x.sign = r[n-1];
    x.cout = 1'b0;
    x.ovr  = 1'b0;
    if (k != 0) begin
      case (o.opr)
        3'b000: x.cout = a[n-k];
        3'b001, 3'b101: x.cout = a[k-1];
        3'b010: x.cout = r[0];
        3'b011: x.cout = r[n-1];
        default: x.cout = 1'b0;
      endcase
    end
    if (o.opr == 3'b000) begin
      one = 1;
      v = '0;
      for (int i = 0; i < n; i++) v[i] = a[i];
      if (a[n-1]) v = v - (one <<< n);
      v = v <<< k;
      lim = one <<< (n - 1);
      x.ovr = (v >= lim) || (v < -lim);
    end
    x.dst = o.dst;
    x.sr  = o.sd;
    return x;
  endfunction

  function automatic op_t cur_op();
    op_t o;
    o.opr = bus.opr; o.a = bus.a; o.b = bus.b; o.c = bus.c; o.d = bus.d;
    o.sa = bus.sa; o.sd = bus.sd; o.dst = bus.dsti;
    return o;
  endfunction

  function automatic op_t mk(input logic [2:0] opr, input logic [63:0] a, input logic [5:0] b,
                             input logic [6:0] c, input logic [63:0] d, input logic [2:0] sa);
    op_t o;
    o.opr = opr; o.a = a; o.b = b; o.c = c; o.d = d; o.sa = sa;
    o.sd = 3'($urandom_range(0, 7));
    o.dst = 5'($urandom_range(0, 31));
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.opr = 3'($urandom_range(0, 7));
    o.a   = {$urandom, $urandom};
    o.b   = 6'($urandom_range(0, 63));
    o.c   = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 16));
    o.d   = {$urandom, $urandom};
    o.sa  = 3'($urandom_range(0, 7));
    o.sd  = 3'($urandom_range(0, 7));
    o.dst = 5'($urandom_range(0, 31));
    return o;
  endfunction

  task automatic set_op(input op_t o);
    bus.opr = o.opr; bus.a = o.a; bus.b = o.b; bus.c = o.c; bus.d = o.d;
    bus.sa = o.sa; bus.sd = o.sd; bus.dsti = o.dst;
  endtask

  // Scoreboard. A result counts as delivered only on an edge that was not stalled.
  always @(posedge clk) begin
    res_t e;
    #1;
    check("busy", 64'(bus.busy), 64'(bus.stall));
    if (reset) begin
      q.delete();
    end else begin
      if (bus.rdy && !bus.stall) begin
        if (q.size() == 0) begin
          check("stale_rdy", 64'(1), 64'(0));
        end else begin
          e = q.pop_front();
          check("r", bus.r, e.r);
          check("flags", 64'({bus.zero, bus.sign, bus.cout, bus.ovr}),
                64'({e.zero, e.sign, e.cout, e.ovr}));
          check("tag", 64'({bus.dsto, bus.sr}), 64'({e.dst, e.sr}));
        end
      end
      if (bus.act && !bus.stall) q.push_back(model(cur_op()));
    end
  end

  // A single isolated op with an exact latency check. exp_f packs {zero, sign, cout, ovr}.
  task automatic run_one(input string tag, input op_t o, input logic [63:0] exp_r, input logic [3:0] exp_f);
    int cnt;
    @(negedge clk);
    set_op(o);
    bus.act = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    bus.act = 1'b0;
    cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.rdy) begin cnt = i; break; end
    end
    if (cnt == 0) begin
      check({tag, "_lat"}, 64'(11), 64'(2));
    end else begin
      check({tag, "_lat"}, 64'(cnt), 64'(2));
      check({tag, "_r"}, bus.r, exp_r);
      check({tag, "_f"}, 64'({bus.zero, bus.sign, bus.cout, bus.ovr}), 64'(exp_f));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    reset = 1'b1;
    bus.act = 1'b0;
    bus.stall = 1'b0;
    set_op(mk(3'b000, 64'h0, 6'd0, 7'd0, 64'h0, 3'd0));
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", 64'(bus.rdy), 64'(0));
    check("rst_r", bus.r, 64'h0);
    check("rst_out", 64'({bus.zero, bus.sign, bus.cout, bus.ovr, bus.dsto, bus.sr}), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    run_one("lsl81",  mk(3'b000, 64'h81, 6'd1, 7'd0, 64'h0, 3'd0), 64'h02, 4'b0011);
    run_one("asr",    mk(3'b101, 64'h8000, 6'd15, 7'd0, 64'h0, 3'd1), 64'hFFFF, 4'b0100);
    run_one("ror",    mk(3'b011, 64'h1, 6'd1, 7'd0, 64'h0, 3'd3), 64'h8000_0000_0000_0000, 4'b0110);
    run_one("set_d1", mk(3'b110, 64'hF, 6'd4, 7'd4, 64'hFFFF, 3'd3), 64'hFFFF, 4'b0000);
    run_one("set_d0", mk(3'b110, 64'hF, 6'd4, 7'd4, 64'h0, 3'd3), 64'hF0, 4'b0000);
    run_one("get",    mk(3'b111, 64'hABCD, 6'd4, 7'd8, 64'h0, 3'd3), 64'hBC, 4'b0000);
    run_one("wrap",   mk(3'b000, 64'h1, 6'd9, 7'd0, 64'h0, 3'd0), 64'h02, 4'b0000);
    run_one("rsv",    mk(3'b100, 64'hFFFF, 6'd3, 7'd5, 64'h1234, 3'd3), 64'h0, 4'b1000);
    run_one("set_c0", mk(3'b110, 64'hF, 6'd2, 7'd0, 64'h1FF, 3'd0), 64'hFF, 4'b0100);
    run_one("get_c0", mk(3'b111, 64'hFF, 6'd0, 7'd0, 64'h0, 3'd3), 64'h0, 4'b1000);
    run_one("clamp",  mk(3'b010, 64'h8000_0000_0000_0001, 6'd4, 7'd0, 64'h0, 3'd7), 64'h18, 4'b0000);

    // Four back-to-back ops with a two-cycle stall in the middle. The held op is re-presented.
    @(negedge clk); set_op(rand_op()); bus.act = 1'b1;
    @(negedge clk); set_op(rand_op());
    @(negedge clk); set_op(rand_op()); bus.stall = 1'b1;
    @(negedge clk);
    @(negedge clk); bus.stall = 1'b0;
    @(negedge clk); set_op(rand_op());
    @(negedge clk); bus.act = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("stall_drain", 64'(q.size()), 64'(0));

    // Reset with two ops in flight, plus an op presented on the reset edge itself.
    @(negedge clk); set_op(rand_op()); bus.act = 1'b1;
    @(negedge clk); set_op(rand_op());
    @(negedge clk); set_op(rand_op()); reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_fl_rdy", 64'(bus.rdy), 64'(0));
    check("rst_fl_r", bus.r, 64'h0);
    check("rst_fl_out", 64'({bus.zero, bus.sign, bus.cout, bus.ovr, bus.dsto, bus.sr}), 64'(0));
    @(negedge clk); reset = 1'b0; bus.act = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (bus.rdy) seen++;
    end
    check("rst_no_stale", 64'(seen), 64'(0));

    // Random traffic with random stalls.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      bus.stall = ($urandom_range(0, 5) == 0);
      bus.act   = ($urandom_range(0, 3) != 0);
      set_op(rand_op());
    end
    @(negedge clk);
    bus.act = 1'b0;
    bus.stall = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("rand_drain", 64'(q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
